// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting four requesters exclusive write access to one shared register.
// Optional macro REG_SHARE_PARITY_EN adds a registered even-parity output q_par.
module reg_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [3:0]         wr_en,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
`ifdef REG_SHARE_PARITY_EN
    output logic               q_par,
`endif
    output logic [WIDTH-1:0]   q
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_OWN     = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;
    localparam logic [3:0] HOLD_LAST  = 4'(MAX_HOLD - 1);

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       ptr_r;
    logic [3:0]       hold_cnt_r;
    logic [3:0]       gnt_r;
    logic [1:0]       owner_r;
    logic             busy_r;
    logic [WIDTH-1:0] q_r;

    logic [1:0]       cand_s;
    logic [1:0]       pick_idx_s;
    logic             pick_found_s;
    logic             write_s;
    logic             release_s;
    logic [WIDTH-1:0] wsel_s;

    // Rotating-priority search; scanning offsets downward lets the nearest requester win.
    always_comb begin
        cand_s       = 2'b00;
        pick_idx_s   = ptr_r;
        pick_found_s = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            cand_s = ptr_r + 2'(k);
            if (req[cand_s]) begin
                pick_idx_s   = cand_s;
                pick_found_s = 1'b1;
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Owner write selection and end-of-tenure detection.
    always_comb begin
        wsel_s    = wdata[owner_r*WIDTH +: WIDTH];
        write_s   = (state_r == ST_OWN) && wr_en[owner_r];
        release_s = (state_r == ST_OWN) && (!req[owner_r] || (hold_cnt_r == HOLD_LAST));
    end

    // Arbitration FSM with grant, owner, busy and hold counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'b00;
            hold_cnt_r <= 4'h0;
            gnt_r      <= 4'b0000;
            owner_r    <= 2'b00;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        gnt_r      <= 4'b0001 << pick_idx_s;
                        owner_r    <= pick_idx_s;
                        hold_cnt_r <= 4'h0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_OWN;
                    end else begin
                        gnt_r      <= 4'b0000;
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        state_r <= ST_RELEASE;
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                        ptr_r   <= owner_r + 2'd1;
                    end else if (hold_cnt_r != HOLD_LAST) begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shared data register; only the current owner's strobe is honoured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= '0;
        end else if (write_s) begin
            q_r <= wsel_s;
        end
    end

`ifdef REG_SHARE_PARITY_EN
    logic q_par_r;

    // Parity tracks q on the same edge, computed from the incoming data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_par_r <= 1'b0;
        end else if (write_s) begin
            q_par_r <= even_parity(wsel_s);
        end
    end

    assign q_par = q_par_r;
`endif

    assign gnt   = gnt_r;
    assign owner = owner_r;
    assign busy  = busy_r;
    assign q     = q_r;

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared D-flip-flop data register.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive ownership cycles per grant; legal range 1..15.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  4  per-requester ownership request; bit i belongs to requester i.
REQ-006 Port wr_en  input  4  per-requester write strobe; bit i belongs to requester i.
REQ-007 Port wdata  input  4*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt  output  4  registered one-hot grant, or all zero.
REQ-009 Port owner  output  2  index of the current or last owner.
REQ-010 Port busy  output  1  high whenever the FSM is in OWN.
REQ-011 Port q  output  WIDTH  shared register contents.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN and RELEASE.
REQ-013 In IDLE, when req is non-zero, the block SHALL select the first requester with req set, searching ptr, ptr+1, ... mod 4. It SHALL load gnt one-hot and owner, clear hold_cnt, and enter OWN on the same edge.
REQ-014 Grant latency SHALL be one cycle: req sampled at edge N gives gnt visible after edge N.
REQ-015 In IDLE with req all zero, the block SHALL stay in IDLE with gnt = 0.
REQ-016 In OWN, when wr_en[owner] = 1, q SHALL load wdata[owner] at the clock edge. wr_en bits of non-owners SHALL be ignored.
REQ-017 q SHALL hold its value in every cycle without an accepted write, including in IDLE and RELEASE.
REQ-018 In OWN, hold_cnt SHALL increment by one per cycle, saturating at MAX_HOLD-1.
REQ-019 OWN SHALL exit to RELEASE when req[owner] = 0 or hold_cnt = MAX_HOLD-1. On that edge, gnt SHALL clear and ptr SHALL become (owner+1) mod 4.
REQ-020 A write strobed in the final OWN cycle, including one that coincides with the timeout, SHALL be accepted.
REQ-021 RELEASE SHALL last exactly one cycle with gnt = 0 and busy = 0, then go to IDLE. Requests are not sampled in RELEASE.
REQ-022 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,... Each tenure SHALL be MAX_HOLD cycles, separated by one RELEASE and one IDLE cycle.
REQ-023 owner SHALL retain its last value outside OWN.
REQ-024 Deasserting req[owner] and asserting another req in the same cycle SHALL end the current tenure normally. The new request is served through IDLE.

Reset
REQ-025 Assertion of reset_n = 0 SHALL immediately, without a clock, force the following: state = IDLE, gnt = 0, owner = 0, busy = 0, q = 0, ptr = 0, hold_cnt = 0.
REQ-026 Reset asserted during OWN SHALL abort the tenure. No write in progress on that edge SHALL reach q.
REQ-027 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge with reset_n = 1.

Configuration
REQ-028 Macro REG_SHARE_PARITY_EN, when defined, SHALL add output port q_par (1 bit). q_par is the registered even parity (XOR reduction) of q. It updates on the same edge as q and resets to 0.
REQ-029 When REG_SHARE_PARITY_EN is undefined, port q_par and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset check: reset_n = 0 mid-OWN with q = 8'hA5 -> gnt = 0, q = 8'h00, busy = 0 immediately, before the next clock edge.
REQ-031 Single requester: req = 4'b0100 at edge 1, wr_en[2] = 1, wdata[2] = 8'h3C at edge 2 -> gnt = 4'b0100 after edge 1, q = 8'h3C after edge 2, owner = 2.
REQ-032 Timeout, MAX_HOLD = 4: req[1] held high -> gnt[1] high for exactly 4 cycles, then 1 RELEASE cycle and 1 IDLE cycle, then a re-grant to 1.
REQ-033 Round-robin: req = 4'b1111 after reset -> grant order 0,1,2,3,0. A write from a non-owner (wr_en[3] = 1 while owner = 0) leaves q unchanged.
REQ-034 Early release: req[0] drops after 2 OWN cycles while req[3] = 1 -> RELEASE, IDLE, then gnt = 4'b1000 (ptr = 1 searches 1,2,3).
REQ-035 With REG_SHARE_PARITY_EN defined: write 8'h07 -> q_par = 1; write 8'h03 -> q_par = 0.
